fixed_order_scheduler: RTL and testbench

Block-level controller for the fixed-LPC encoder stage. Accepts one block of PCM samples per `iStart`, computes the fixed-predictor residuals for orders 0–4 through a residual bank, and accumulates the sum of absolute residuals per order. It then scans the sums and reports the cheapest order, with its cost, to the frame builder. It sits between the sample buffer and the fixed encoder, and tells that encoder which order to run for the block.

---
 rtl/fixed_order_scheduler_pkg.sv | 34 +++
 rtl/fixed_order_scheduler_residual_bank.sv | 71 +++++++
 rtl/fixed_order_scheduler.sv | 185 ++++++++++++++++++
 tb/tb_fixed_order_scheduler.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_order_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package  : fixed_sched_pkg
// Brief    : Shared constants and FSM encoding for the fixed-order scheduler.
// Options  : FIXED_SCHED_ORDER4_EN selects MAX_ORDER = 4 (else 3).
// Revision : 1.0
// ============================================================================
package fixed_sched_pkg;

`ifdef FIXED_SCHED_ORDER4_EN
    localparam int MAX_ORDER = 4;
`else
    localparam int MAX_ORDER = 3;
`endif

    localparam int NUM_ORDERS = MAX_ORDER + 1;
    localparam int WARMUP     = 4;
    localparam int RES_GUARD  = 5;

    // Worst-case order-4 gain is 16, so five guard bits cover every residual.
    function automatic int res_width(input int sample_w);
        return sample_w + RES_GUARD;
    endfunction

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILL    = 3'd1,
        ST_DRAIN   = 3'd2,
        ST_COMPARE = 3'd3,
        ST_DONE    = 3'd4
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/fixed_order_scheduler_residual_bank.sv
`default_nettype none
// ============================================================================
// Module   : fixed_residual_bank
// Brief    : Sample history plus registered fixed-predictor residuals r0..rN.
// Options  : FIXED_SCHED_ORDER4_EN adds the order-4 residual.
// Revision : 1.0
// ============================================================================
module fixed_residual_bank
    import fixed_sched_pkg::*;
#(
    parameter int SAMPLE_W = 16,
    parameter int RES_W    = res_width(SAMPLE_W)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_clear,
    input  logic                       i_shift,
    input  logic                       i_qualify,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    output logic signed [RES_W-1:0]    o_res [NUM_ORDERS],
    output logic                       o_res_valid
);

    logic signed [SAMPLE_W-1:0] r_hist [MAX_ORDER];
    logic signed [RES_W-1:0]    w_d    [NUM_ORDERS];
    logic signed [RES_W-1:0]    w_res  [NUM_ORDERS];
    logic signed [RES_W-1:0]    r_res  [NUM_ORDERS];
    logic                       r_res_valid;

    // w_d[0] is the incoming (newest) sample, w_d[k] the k-th older one.
    assign w_d[0] = RES_W'(i_sample);
    for (genvar k = 1; k < NUM_ORDERS; k++) begin : g_hist_ext
        assign w_d[k] = RES_W'(r_hist[k-1]);
    end

    assign w_res[0] = w_d[0];
    assign w_res[1] = w_d[0] - w_d[1];
    assign w_res[2] = w_d[0] - (w_d[1] <<< 1) + w_d[2];
    assign w_res[3] = w_d[0] - (w_d[1] <<< 1) - w_d[1]
                    + (w_d[2] <<< 1) + w_d[2] - w_d[3];
`ifdef FIXED_SCHED_ORDER4_EN
    assign w_res[4] = w_d[0] - (w_d[1] <<< 2) + (w_d[2] <<< 2) + (w_d[2] <<< 1)
                    - (w_d[3] <<< 2) + w_d[4];
`endif

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MAX_ORDER; k++)  r_hist[k] <= '0;
            for (int k = 0; k < NUM_ORDERS; k++) r_res[k]  <= '0;
            r_res_valid <= 1'b0;
        end else if (i_clear) begin
            for (int k = 0; k < MAX_ORDER; k++)  r_hist[k] <= '0;
            for (int k = 0; k < NUM_ORDERS; k++) r_res[k]  <= '0;
            r_res_valid <= 1'b0;
        end else begin
            r_res_valid <= i_shift & i_qualify;
            if (i_shift) begin
                r_hist[0] <= i_sample;
                for (int k = 1; k < MAX_ORDER; k++)  r_hist[k] <= r_hist[k-1];
                for (int k = 0; k < NUM_ORDERS; k++) r_res[k]  <= w_res[k];
            end
        end
    end

    for (genvar k = 0; k < NUM_ORDERS; k++) begin : g_res_out
        assign o_res[k] = r_res[k];
    end
    assign o_res_valid = r_res_valid;

endmodule
`default_nettype wire

// File: rtl/fixed_order_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fixed_order_scheduler
// Brief    : Scores fixed-LPC orders over one block and reports the cheapest.
// Options  : FIXED_SCHED_ORDER4_EN enables order 4 (default build: orders 0-3).
// Revision : 1.0
// ============================================================================
module fixed_order_scheduler
    import fixed_sched_pkg::*;
#(
    parameter int BLOCK_SIZE = 4096,
    parameter int SAMPLE_W   = 16,
    parameter int ACC_W      = 32
) (
    input  logic                       iClock,
    input  logic                       iReset,
    input  logic                       iStart,
    input  logic                       iValid,
    input  logic signed [SAMPLE_W-1:0] iSample,
    output logic                       oReady,
    output logic                       oBusy,
    output logic                       oDone,
    output logic [2:0]                 oBestOrder,
    output logic [ACC_W-1:0]           oBestSum
);

    localparam int RES_W = res_width(SAMPLE_W);
    localparam int SUM_W = ((ACC_W > RES_W) ? ACC_W : RES_W) + 1;
    localparam int CNT_W = $clog2(BLOCK_SIZE + 1);
    localparam int IDX_W = $clog2(NUM_ORDERS);

    localparam logic [CNT_W-1:0] c_last_idx   = CNT_W'(BLOCK_SIZE - 1);
    localparam logic [CNT_W-1:0] c_warmup     = CNT_W'(WARMUP);
    localparam logic [IDX_W-1:0] c_last_order = IDX_W'(MAX_ORDER);
    localparam logic [SUM_W-1:0] c_sat        = SUM_W'({ACC_W{1'b1}});

    sched_state_t            r_state;
    sched_state_t            w_state_next;
    logic [CNT_W-1:0]        r_count;
    logic                    r_drain;
    logic [IDX_W-1:0]        r_cmp_idx;
    logic [IDX_W-1:0]        r_best_idx;
    logic [ACC_W-1:0]        r_best_sum;
    logic [ACC_W-1:0]        r_sum      [NUM_ORDERS];
    logic [ACC_W-1:0]        w_sum_next [NUM_ORDERS];
    logic signed [RES_W-1:0] w_res      [NUM_ORDERS];
    logic [2:0]              r_out_order;
    logic [ACC_W-1:0]        r_out_sum;

    logic                    w_res_valid;
    logic                    w_ready;
    logic                    w_xfer;
    logic                    w_clear;
    logic                    w_qualify;
    logic                    w_take;
    logic [ACC_W-1:0]        w_cand_sum;
    logic [ACC_W-1:0]        w_best_sum_next;
    logic [IDX_W-1:0]        w_best_idx_next;

    // The sum is widened past both operands so the saturation test cannot wrap.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0]       acc,
                                                 input logic signed [RES_W-1:0] res);
        logic [RES_W-1:0] mag;
        logic [SUM_W-1:0] total;
        mag   = res[RES_W-1] ? -res : res;
        total = SUM_W'(acc) + SUM_W'(mag);
        return (total > c_sat) ? {ACC_W{1'b1}} : total[ACC_W-1:0];
    endfunction

    assign w_clear   = (r_state == ST_IDLE) && iStart;
    assign w_xfer    = iValid && w_ready;
    assign w_qualify = (r_count >= c_warmup);

    fixed_residual_bank #(
        .SAMPLE_W (SAMPLE_W),
        .RES_W    (RES_W)
    ) u_residual_bank (
        .clk         (iClock),
        .rst_n       (iReset),
        .i_clear     (w_clear),
        .i_shift     (w_xfer),
        .i_qualify   (w_qualify),
        .i_sample    (iSample),
        .o_res       (w_res),
        .o_res_valid (w_res_valid)
    );

    always_comb begin
        for (int k = 0; k < NUM_ORDERS; k++) begin
            w_sum_next[k] = sat_add(r_sum[k], w_res[k]);
        end
    end

    // Order 0 seeds the best; later orders win only when strictly cheaper.
    assign w_cand_sum      = r_sum[r_cmp_idx];
    assign w_take          = (r_cmp_idx == '0) || (w_cand_sum < r_best_sum);
    assign w_best_sum_next = w_take ? w_cand_sum : r_best_sum;
    assign w_best_idx_next = w_take ? r_cmp_idx  : r_best_idx;

    always_ff @(negedge iClock or negedge iReset) begin
        if (!iReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ready      = 1'b0;
        oBusy        = 1'b1;
        oDone        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                oBusy = 1'b0;
                if (iStart) w_state_next = ST_FILL;
            end
            ST_FILL: begin
                w_ready = 1'b1;
                if (iValid && (r_count == c_last_idx)) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (r_drain) w_state_next = ST_COMPARE;
            end
            ST_COMPARE: begin
                if (r_cmp_idx == c_last_order) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                oDone        = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                oBusy        = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(negedge iClock or negedge iReset) begin
        if (!iReset) begin
            r_count     <= '0;
            r_drain     <= 1'b0;
            r_cmp_idx   <= '0;
            r_best_idx  <= '0;
            r_best_sum  <= '0;
            r_out_order <= '0;
            r_out_sum   <= '0;
            for (int k = 0; k < NUM_ORDERS; k++) r_sum[k] <= '0;
        end else begin
            if (w_clear) begin
                r_count <= '0;
            end else if (w_xfer) begin
                r_count <= r_count + CNT_W'(1);
            end

            r_drain <= (r_state == ST_DRAIN) ? ~r_drain : 1'b0;

            if (r_state == ST_COMPARE) begin
                r_cmp_idx  <= r_cmp_idx + IDX_W'(1);
                r_best_idx <= w_best_idx_next;
                r_best_sum <= w_best_sum_next;
                if (r_cmp_idx == c_last_order) begin
                    r_out_order <= 3'(w_best_idx_next);
                    r_out_sum   <= w_best_sum_next;
                end
            end else begin
                r_cmp_idx <= '0;
            end

            for (int k = 0; k < NUM_ORDERS; k++) begin
                if (w_clear) begin
                    r_sum[k] <= '0;
                end else if (w_res_valid) begin
                    r_sum[k] <= w_sum_next[k];
                end
            end
        end
    end

    assign oReady     = w_ready;
    assign oBestOrder = r_out_order;
    assign oBestSum   = r_out_sum;

endmodule
`default_nettype wire

// File: tb/tb_fixed_order_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fixed_order_scheduler
// Brief    : Scoreboard bench; u_dut (ACC_W=32) and u_sat (ACC_W=18).
// Revision : 1.0
// ============================================================================
module tb_fixed_order_scheduler;

    localparam int N = 16;
`ifdef FIXED_SCHED_ORDER4_EN
    localparam int LAT       = 8;
    localparam int CUBIC_ORD = 4;
    localparam int CUBIC_SUM = 0;
`else
    // Third difference of n^3 is the constant 6: 12 scored samples -> 72.
    localparam int LAT       = 7;
    localparam int CUBIC_ORD = 3;
    localparam int CUBIC_SUM = 72;
`endif

    typedef struct {
        int ord;
        int sum;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start_m;
    logic               start_s;
    logic               valid;
    logic signed [15:0] sample;

    logic               rdy_m, busy_m, done_m;
    logic [2:0]         ord_m;
    logic [31:0]        sum_m;
    logic               rdy_s, busy_s, done_s;
    logic [2:0]         ord_s;
    logic [17:0]        sum_s;

    exp_t q_m[$];
    exp_t q_s[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    fixed_order_scheduler #(.BLOCK_SIZE(N), .SAMPLE_W(16), .ACC_W(32)) u_dut (
        .iClock(clk), .iReset(rst_n), .iStart(start_m), .iValid(valid), .iSample(sample),
        .oReady(rdy_m), .oBusy(busy_m), .oDone(done_m), .oBestOrder(ord_m), .oBestSum(sum_m)
    );

    fixed_order_scheduler #(.BLOCK_SIZE(N), .SAMPLE_W(16), .ACC_W(18)) u_sat (
        .iClock(clk), .iReset(rst_n), .iStart(start_s), .iValid(valid), .iSample(sample),
        .oReady(rdy_s), .oBusy(busy_s), .oDone(done_s), .oBestOrder(ord_s), .oBestSum(sum_s)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [15:0] samp(input int pat, input int n);
        case (pat)
            0:       return 16'sd1000;
            1:       return 16'(10 * n);
            2:       return (n % 2 == 0) ? 16'sd32767 : -16'sd32767;
            default: return 16'(n * n * n);
        endcase
    endfunction

    // Monitor: one sample point per cycle, 1 time unit after the posedge.
    initial begin : monitor
        int   last_m;
        int   last_s;
        bit   prev_m;
        bit   prev_s;
        exp_t e;
        last_m = 0; last_s = 0; prev_m = 0; prev_s = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev_m = 0;
                prev_s = 0;
            end else begin
                if (valid && rdy_m) last_m = cyc;
                if (valid && rdy_s) last_s = cyc;
                if (prev_m) check("done_pulse_m", done_m, 0);
                if (prev_s) check("done_pulse_s", done_s, 0);
                if (done_m) begin
                    if (q_m.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL done_m: oDone=1 with no block outstanding");
                    end else begin
                        e = q_m.pop_front();
                        check("best_order_m", ord_m, e.ord);
                        check("best_sum_m", sum_m, e.sum);
                        check("done_latency_m", cyc - last_m, LAT);
                    end
                end
                if (done_s) begin
                    if (q_s.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL done_s: oDone=1 with no block outstanding");
                    end else begin
                        e = q_s.pop_front();
                        check("best_order_s", ord_s, e.ord);
                        check("best_sum_s", sum_s, e.sum);
                        check("done_latency_s", cyc - last_s, LAT);
                    end
                end
                prev_m = done_m;
                prev_s = done_s;
            end
        end
    end

    task automatic feed(input int d, input int pat, input bit gaps);
        int g;
        @(posedge clk);
        if (d == 0) start_m = 1'b1; else start_s = 1'b1;
        @(posedge clk);
        start_m = 1'b0;
        start_s = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (gaps) begin
                g = (i == 8) ? 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
                for (int k = 0; k < g; k++) begin
                    valid   = 1'b0;
                    sample  = 16'($urandom);
                    start_m = (d == 0) && (i == 8) && (k == 0);
                    @(posedge clk);
                    start_m = 1'b0;
                end
            end
            valid  = 1'b1;
            sample = samp(pat, i);
            @(posedge clk);
        end
        if (gaps) begin
            sample = 16'sh7fff;
            repeat (3) @(posedge clk);
        end
        valid  = 1'b0;
        sample = '0;
    endtask

    task automatic wait_done(input int d);
        int k;
        k = 0;
        while (((d == 0) ? q_m.size() : q_s.size()) > 0 && k < 40) begin
            @(posedge clk);
            k++;
        end
        if (((d == 0) ? q_m.size() : q_s.size()) > 0) begin
            checks++; fails++;
            $display("FAIL timeout_%0d: oDone not seen within 40 cycles", d);
            if (d == 0) q_m.delete(); else q_s.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic run(input int d, input int pat, input bit gaps, input int e_ord, input int e_sum);
        exp_t e;
        e.ord = e_ord;
        e.sum = e_sum;
        if (d == 0) q_m.push_back(e); else q_s.push_back(e);
        feed(d, pat, gaps);
        wait_done(d);
    endtask

    initial begin : stimulus
        rst_n = 1'b0; start_m = 1'b0; start_s = 1'b0; valid = 1'b0; sample = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", rdy_m, 0);
        check("reset_busy", busy_m, 0);
        check("reset_done", done_m, 0);
        check("reset_order", ord_m, 0);
        check("reset_sum", sum_m, 0);
        @(posedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run(0, 0, 1'b0, 1, 0);          // constant: tie at 0 resolves to order 1
        run(0, 1, 1'b0, 2, 0);          // ramp: sum1=120, sum2=0
        run(0, 1, 1'b1, 2, 0);          // ramp with gaps and a mid-FILL iStart
        run(0, 2, 1'b0, 0, 393204);     // alternating, unsaturated
        run(1, 2, 1'b0, 0, 262143);     // alternating, every order saturated
        run(0, 3, 1'b0, CUBIC_ORD, CUBIC_SUM);

        // Abort a block after 7 samples with an asynchronous reset.
        @(posedge clk);
        start_m = 1'b1;
        @(posedge clk);
        start_m = 1'b0;
        for (int i = 0; i < 7; i++) begin
            valid  = 1'b1;
            sample = samp(2, i);
            @(posedge clk);
        end
        valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_ready", rdy_m, 0);
        check("abort_busy", busy_m, 0);
        check("abort_done", done_m, 0);
        check("abort_order", ord_m, 0);
        check("abort_sum", sum_m, 0);
        check("abort_sum_sat", sum_s, 0);
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run(0, 0, 1'b0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
